// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel prescaler, h/v counters, pixel address
// publication and a one-pixel registered colour/sync output stage.
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [11:0] COLOUR_IN,
    output logic [9:0]  ADDRH,
    output logic [8:0]  ADDRV,
    output logic        DISP_EN,
    output logic        FRAME_START,
    output logic        HS,
    output logic        VS,
    output logic [11:0] COLOUR_OUT
);

    localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PCNT_MAX   = PW'(CLK_DIV - 1);
    localparam logic [9:0]    H_DISP_C   = 10'(H_DISP);
    localparam logic [9:0]    H_LAST_C   = 10'(H_TOT - 1);
    localparam logic [9:0]    HS_FIRST_C = 10'(H_DISP + H_FP);
    localparam logic [9:0]    HS_LAST_C  = 10'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [9:0]    V_DISP_C   = 10'(V_DISP);
    localparam logic [9:0]    V_LAST_C   = 10'(V_TOT - 1);
    localparam logic [9:0]    VS_FIRST_C = 10'(V_DISP + V_FP);
    localparam logic [9:0]    VS_LAST_C  = 10'(V_DISP + V_FP + V_SYNC - 1);

    logic [PW-1:0] pcnt_r;
    logic [9:0]    hcnt_r;
    logic [9:0]    vcnt_r;
    logic [9:0]    h_next_s;
    logic [9:0]    v_next_s;
    logic          pix_en_s;
    logic          h_vis_s;
    logic          v_vis_s;
    logic          disp_en_s;
    logic          h_sync_s;
    logic          v_sync_s;
    logic [9:0]    addrh_s;
    logic [8:0]    addrv_s;
    logic [11:0]   colour_r;
    logic          hs_r;
    logic          vs_r;

    assign pix_en_s = (pcnt_r == PCNT_MAX);

    // Next raster position: vertical advances only when the line wraps.
    always_comb begin
        h_next_s = hcnt_r;
        v_next_s = vcnt_r;
        if (hcnt_r == H_LAST_C) begin
            h_next_s = 10'd0;
            if (vcnt_r == V_LAST_C) begin
                v_next_s = 10'd0;
            end else begin
                v_next_s = vcnt_r + 10'd1;
            end
        end else begin
            h_next_s = hcnt_r + 10'd1;
        end
    end

    // Prescaler and raster counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pcnt_r <= PW'(0);
            hcnt_r <= 10'd0;
            vcnt_r <= 10'd0;
        end else if (pix_en_s) begin
            pcnt_r <= PW'(0);
            hcnt_r <= h_next_s;
            vcnt_r <= v_next_s;
        end else begin
            pcnt_r <= pcnt_r + PW'(1);
        end
    end

    // Region decode for the current counter position.
    always_comb begin
        h_vis_s   = (hcnt_r < H_DISP_C);
        v_vis_s   = (vcnt_r < V_DISP_C);
        disp_en_s = h_vis_s && v_vis_s;
        h_sync_s  = (hcnt_r >= HS_FIRST_C) && (hcnt_r <= HS_LAST_C);
        v_sync_s  = (vcnt_r >= VS_FIRST_C) && (vcnt_r <= VS_LAST_C);
        if (h_vis_s) begin
            addrh_s = hcnt_r;
        end else begin
            addrh_s = 10'd0;
        end
        if (v_vis_s) begin
            addrv_s = vcnt_r[8:0];
        end else begin
            addrv_s = 9'd0;
        end
    end

    // Colour and syncs share one pipeline stage so they leave the pins together.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            colour_r <= 12'h000;
            hs_r     <= 1'b1;
            vs_r     <= 1'b1;
        end else if (pix_en_s) begin
            colour_r <= disp_en_s ? COLOUR_IN : 12'h000;
            hs_r     <= ~h_sync_s;
            vs_r     <= ~v_sync_s;
        end else begin
            colour_r <= colour_r;
            hs_r     <= hs_r;
            vs_r     <= vs_r;
        end
    end

    assign ADDRH       = addrh_s;
    assign ADDRV       = addrv_s;
    assign DISP_EN     = disp_en_s;
    assign FRAME_START = pix_en_s && (hcnt_r == 10'd0) && (vcnt_r == 10'd0);
    assign HS          = hs_r;
    assign VS          = vs_r;
    assign COLOUR_OUT  = colour_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen using a reduced raster so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int CD     = 4;
    localparam int HD     = 8;
    localparam int HFP    = 2;
    localparam int HSY    = 3;
    localparam int HBP    = 2;
    localparam int VD     = 4;
    localparam int VFP    = 1;
    localparam int VSY    = 2;
    localparam int VBP    = 1;
    localparam int HT     = HD + HFP + HSY + HBP;   // 15 pixels per line
    localparam int VT     = VD + VFP + VSY + VBP;   // 8 lines per frame
    localparam int FRAME_CLKS = 480;                // 15*8*4
    localparam int HS_LOW_CLKS = 12;                // 3 pixels * 4
    localparam int VS_LOW_CLKS = 120;               // 2 lines * 15 * 4

    typedef struct {
        logic        rst;
        logic [9:0]  addrh;
        logic [8:0]  addrv;
        logic        disp_en;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] col;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        mode;
    logic [11:0] colour_in;
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic        disp_en;
    logic        frame_start;
    logic        hs;
    logic        vs;
    logic [11:0] colour_out;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    vga_timing_gen #(
        .CLK_DIV(CD), .H_DISP(HD), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_DISP(VD), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .CLK(clk), .RESET(reset), .COLOUR_IN(colour_in),
        .ADDRH(addrh), .ADDRV(addrv), .DISP_EN(disp_en), .FRAME_START(frame_start),
        .HS(hs), .VS(vs), .COLOUR_OUT(colour_out)
    );

    // Colour source: constant pattern or the published column address.
    assign colour_in = mode ? {2'b00, addrh} : 12'hABC;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: position derived from elapsed clocks since reset.
    int          t = 0;
    logic        rhs = 1'b1;
    logic        rvs = 1'b1;
    logic [11:0] rcol = 12'h000;
    always @(posedge clk) begin
        exp_t e;
        int   p, h, v;
        #1;
        if (reset) begin
            t = 0; rhs = 1'b1; rvs = 1'b1; rcol = 12'h000;
        end else begin
            if (t % CD == CD - 1) begin
                p = (t / CD) % (HT * VT);
                h = p % HT;
                v = p / HT;
                rhs  = !(h >= HD + HFP && h < HD + HFP + HSY);
                rvs  = !(v >= VD + VFP && v < VD + VFP + VSY);
                rcol = (h < HD && v < VD) ? (mode ? 12'(h) : 12'hABC) : 12'h000;
            end
            t++;
        end
        p = (t / CD) % (HT * VT);
        h = p % HT;
        v = p / HT;
        e.rst     = reset;
        e.addrh   = (h < HD) ? 10'(h) : 10'd0;
        e.addrv   = (v < VD) ? 9'(v) : 9'd0;
        e.disp_en = (h < HD) && (v < VD);
        e.fs      = (t % CD == CD - 1) && (p == 0);
        e.hs      = rhs;
        e.vs      = rvs;
        e.col     = rcol;
        q.push_back(e);
    end

    // Monitor: compares each presented cycle and measures pulse timing.
    int cyc = 0;
    int last_fs = -1;
    int hs_low = 0;
    int vs_low = 0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ADDRH", int'(addrh), int'(e.addrh));
            chk("ADDRV", int'(addrv), int'(e.addrv));
            chk("DISP_EN", int'(disp_en), int'(e.disp_en));
            chk("FRAME_START", int'(frame_start), int'(e.fs));
            chk("HS", int'(hs), int'(e.hs));
            chk("VS", int'(vs), int'(e.vs));
            chk("COLOUR_OUT", int'(colour_out), int'(e.col));
            if (e.rst) begin
                last_fs = -1; hs_low = 0; vs_low = 0;
            end else begin
                if (frame_start) begin
                    if (last_fs >= 0) chk("FS_PERIOD", cyc - last_fs, FRAME_CLKS);
                    last_fs = cyc;
                end
                if (!hs) hs_low++;
                else begin
                    if (hs_low > 0) chk("HS_WIDTH", hs_low, HS_LOW_CLKS);
                    hs_low = 0;
                end
                if (!vs) vs_low++;
                else begin
                    if (vs_low > 0) chk("VS_WIDTH", vs_low, VS_LOW_CLKS);
                    vs_low = 0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        mode  = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (2 * FRAME_CLKS + 10) @(posedge clk);
        #2 mode = 1'b1;
        repeat (2 * FRAME_CLKS) @(posedge clk);
        // Mid-frame reset inside a visible line.
        repeat (197) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        repeat (FRAME_CLKS + 100) @(posedge clk);
        @(negedge clk);
        #1;
        chk("SB_DRAIN", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
